butterfly_pipe_param: RTL and testbench

Parametrised, fully pipelined modular butterfly for the NTT/INTT datapath. It is the successor of the fixed 12-bit Kyber butterfly core, generalised in data width, modulus and multiplier depth. Every mode has the same latency, so mode may change on any beat. A valid/ready handshake with backpressure lets the block sit between the coefficient RAM read port and the write-back FIFO without external delay-matching registers.

---
 rtl/bf_pkg.sv | 50 +++++
 rtl/butterfly_pipe_param_mul.sv | 95 +++++++++
 rtl/butterfly_pipe_param.sv | 150 +++++++++++++++
 tb/tb_butterfly_pipe_param.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// bf_pkg: shared mode encodings and modular helpers for the butterfly.
// Helpers work on a 32-bit word; callers cast to their own width.
package bf_pkg;

  localparam int MAXW = 32;

  typedef logic [MAXW-1:0] word_t;

  typedef enum logic [1:0] {
    MODE_NTT    = 2'd0,
    MODE_INTT   = 2'd1,
    MODE_MULT   = 2'd2,
    MODE_ADDSUB = 2'd3
  } mode_e;

  // floor(2^(2*w) / q), the Barrett constant for a 2w-bit product.
  function automatic logic [63:0] barrett_k(
    input int w,
    input int q
  );
    return (64'd1 << (2 * w)) / 64'(q);
  endfunction

  // (a + b) mod q for a, b < q.
  function automatic word_t mod_add(
    input word_t a,
    input word_t b,
    input word_t q
  );
    logic [MAXW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q})
      s = s - {1'b0, q};
    return s[MAXW-1:0];
  endfunction

  // (a - b) mod q for a, b < q.
  function automatic word_t mod_sub(
    input word_t a,
    input word_t b,
    input word_t q
  );
    logic [MAXW:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b)
      d = d + {1'b0, q};
    return d[MAXW-1:0];
  endfunction

endpackage

// File: rtl/butterfly_pipe_param_mul.sv
// mod_mult_pipe: pipelined a*b mod Q with Barrett reduction.
// Ports: clk, rst_n (sync, low), en (advance), a, b, res (MUL_LAT later).
module mod_mult_pipe
  import bf_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int Q       = 3329,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);

  localparam int PW = 2 * WIDTH;

  typedef logic [PW-1:0] p_t;

  localparam p_t M  = p_t'(barrett_k(WIDTH, Q));
  localparam p_t QP = p_t'(Q);

  // Quotient estimate; never above floor(p/Q), at most 2 below it.
  function automatic p_t qhat(input p_t p);
    logic [2*PW-1:0] pm;
    pm = {{PW{1'b0}}, p} * {{PW{1'b0}}, M};
    return pm[2*PW-1:PW];
  endfunction

  // Remainder is below 3Q, so two conditional subtracts finish it.
  function automatic logic [WIDTH-1:0] fin(
    input p_t p,
    input p_t qh
  );
    p_t r;
    r = p - qh * QP;
    if (r >= QP)
      r = r - QP;
    if (r >= QP)
      r = r - QP;
    return r[WIDTH-1:0];
  endfunction

  p_t pr;
  assign pr = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  if (MUL_LAT == 1) begin : g_l1
    logic [WIDTH-1:0] r1;
    always_ff @(posedge clk) begin
      if (!rst_n)
        r1 <= '0;
      else if (en)
        r1 <= fin(pr, qhat(pr));
    end
    assign res = r1;
  end else if (MUL_LAT == 2) begin : g_l2
    p_t               p1;
    logic [WIDTH-1:0] r2;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        p1 <= '0;
        r2 <= '0;
      end else if (en) begin
        p1 <= pr;
        r2 <= fin(p1, qhat(p1));
      end
    end
    assign res = r2;
  end else begin : g_ln
    p_t               p1;
    p_t               p2;
    p_t               qh2;
    logic [WIDTH-1:0] dl [MUL_LAT-2];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        p1  <= '0;
        p2  <= '0;
        qh2 <= '0;
        for (int i = 0; i < MUL_LAT - 2; i++)
          dl[i] <= '0;
      end else if (en) begin
        p1    <= pr;
        p2    <= p1;
        qh2   <= qhat(p1);
        dl[0] <= fin(p2, qh2);
        for (int i = 1; i < MUL_LAT - 2; i++)
          dl[i] <= dl[i-1];
      end
    end
    assign res = dl[MUL_LAT-3];
  end

endmodule

// File: rtl/butterfly_pipe_param.sv
// butterfly_pipe_param: pipelined NTT/INTT/MULT/ADDSUB butterfly mod Q.
// Ports: clk, rst_n (sync, low), in_valid/in_ready, mode, in_a, in_b,
// coef, out_valid/out_ready, out_1, out_2. Latency LAT = MUL_LAT+1.
// Define INTT_HALVE_EN to scale both INTT outputs by 2^-1 mod Q.
module butterfly_pipe_param
  import bf_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int Q       = 3329,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] coef,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2
);

  localparam int LAT = MUL_LAT + 1;

  typedef logic [WIDTH-1:0] w_t;

  localparam word_t QW = word_t'(Q);
  localparam w_t    QT = w_t'(Q);

  typedef struct packed {
    logic  v;
    mode_e m;
    w_t    c1;
    w_t    c2;
  } side_t;

  logic  adv;
  logic  v0;
  mode_e m0;
  w_t    a0, b0, w0;
  w_t    s0, d0, mx, c1_in, t;
  side_t sd [LAT-1];
  side_t last;
  w_t    o1, o2;

  assign last      = sd[LAT-2];
  assign adv       = !(last.v && !out_ready);
  assign in_ready  = adv;
  assign out_valid = last.v;
  assign out_1     = o1;
  assign out_2     = o2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      m0 <= MODE_NTT;
      a0 <= '0;
      b0 <= '0;
      w0 <= '0;
    end else if (adv) begin
      v0 <= in_valid;
      m0 <= mode_e'(mode);
      a0 <= in_a;
      b0 <= in_b;
      w0 <= coef;
    end
  end

  assign s0 = w_t'(mod_add(word_t'(a0), word_t'(b0), QW));
  assign d0 = w_t'(mod_sub(word_t'(a0), word_t'(b0), QW));

  // INTT multiplies the difference; NTT and MULT multiply b.
  assign mx = (m0 == MODE_INTT) ? d0 : b0;

  // Sum replaces a for the modes that never need a again.
  assign c1_in = (m0 == MODE_INTT || m0 == MODE_ADDSUB) ? s0 : a0;

  mod_mult_pipe #(
    .WIDTH   (WIDTH),
    .Q       (Q),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .a     (mx),
    .b     (w0),
    .res   (t)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT - 1; i++)
        sd[i] <= '0;
    end else if (adv) begin
      sd[0].v  <= v0;
      sd[0].m  <= m0;
      sd[0].c1 <= c1_in;
      sd[0].c2 <= d0;
      for (int i = 1; i < LAT - 1; i++)
        sd[i] <= sd[i-1];
    end
  end

`ifdef INTT_HALVE_EN
  function automatic w_t half(input w_t x);
    logic [WIDTH:0] s;
    s = {1'b0, x};
    if (x[0])
      s = s + (WIDTH+1)'(Q);
    return s[WIDTH:1];
  endfunction
`endif

  always_comb begin
    o1 = last.c1;
    o2 = last.c2;
    unique case (last.m)
      MODE_NTT: begin
        o1 = w_t'(mod_add(word_t'(last.c1), word_t'(t), QW));
        o2 = w_t'(mod_sub(word_t'(last.c1), word_t'(t), QW));
      end
      MODE_INTT: begin
`ifdef INTT_HALVE_EN
        o1 = half(last.c1);
        o2 = half(t);
`else
        o1 = last.c1;
        o2 = t;
`endif
      end
      MODE_MULT: begin
        o2 = t;
      end
      MODE_ADDSUB: begin
        o2 = last.c2;
      end
    endcase
  end

  a_in_range: assert property (
    @(posedge clk) disable iff (!rst_n)
    (in_valid && in_ready) |->
      (in_a < QT && in_b < QT && coef < QT)
  );

endmodule

// File: tb/tb_butterfly_pipe_param.sv
// tb_butterfly_pipe_param: random + directed scoreboard bench.
// Expected results come from a plain-arithmetic model of each mode.
module tb_butterfly_pipe_param;

  localparam int W = 12;
  localparam int Q = 3329;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   mode;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] coef;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_1;
  logic [W-1:0] out_2;

  butterfly_pipe_param #(
    .WIDTH   (W),
    .Q       (Q),
    .MUL_LAT (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .in_a      (in_a),
    .in_b      (in_b),
    .coef      (coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_1     (out_1),
    .out_2     (out_2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int o1;
    int o2;
    int acc;
    int st;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   st    = 0;
  bit   rnd_en  = 1'b0;
  bit   lat_chk = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int halve(input int x);
    return (x % 2 == 0) ? x / 2 : (x + Q) / 2;
  endfunction

  function automatic void model(
    input int m, input int a, input int b, input int w,
    output int o1, output int o2
  );
    int t;
    case (m)
      0: begin
        t  = (b * w) % Q;
        o1 = (a + t) % Q;
        o2 = (a - t + Q) % Q;
      end
      1: begin
        o1 = (a + b) % Q;
        o2 = (((a - b + Q) % Q) * w) % Q;
`ifdef INTT_HALVE_EN
        o1 = halve(o1);
        o2 = halve(o2);
`endif
      end
      2: begin
        o1 = a;
        o2 = (b * w) % Q;
      end
      default: begin
        o1 = (a + b) % Q;
        o2 = (a - b + Q) % Q;
      end
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_en ? ($urandom % 4 != 0) : 1'b1;
    end
  end

  initial begin : mon
    bit     pstall = 1'b0;
    logic [W-1:0] p1 = '0;
    logic [W-1:0] p2 = '0;
    exp_t   e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pstall) begin
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_out_1", int'(out_1), int'(p1));
          chk("hold_out_2", int'(out_2), int'(p2));
        end
        chk("in_ready", int'(in_ready),
            int'(!(out_valid && !out_ready)));
        pstall = out_valid && !out_ready;
        p1 = out_1;
        p2 = out_2;
        if (pstall)
          st++;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("spurious_out", 1, 0);
          end else begin
            e = q.pop_front();
            chk("out_1", int'(out_1), e.o1);
            chk("out_2", int'(out_2), e.o2);
            if (lat_chk)
              chk("latency", cyc - e.acc - (st - e.st), 3);
          end
        end
      end else begin
        pstall = 1'b0;
      end
    end
  end

  task automatic send(
    input int m, input int a, input int b, input int w,
    input int e1, input int e2
  );
    int g = 0;
    bit acc = 1'b0;
    in_valid = 1'b1;
    mode = 2'(m);
    in_a = W'(a);
    in_b = W'(b);
    coef = W'(w);
    while (!acc && g < 200) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        q.push_back('{e1, e2, cyc + 1, st});
      end
      @(posedge clk);
      #1;
      g++;
    end
    if (!acc)
      chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic sendr(input int m);
    int a, b, w, e1, e2;
    a = int'($urandom_range(0, Q - 1));
    b = int'($urandom_range(0, Q - 1));
    w = int'($urandom_range(0, Q - 1));
    model(m, a, b, w, e1, e2);
    send(m, a, b, w, e1, e2);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_out_1"}, int'(out_1), 0);
    chk({tag, "_out_2"}, int'(out_2), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    mode = '0;
    in_a = '0;
    in_b = '0;
    coef = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_idle("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_rst");
    @(posedge clk);
    #1;

    send(0, 1, 2, 17, 35, 3296);
`ifdef INTT_HALVE_EN
    send(1, 5, 3, 17, 4, 17);
`else
    send(1, 5, 3, 17, 8, 34);
`endif
    send(2, 100, 3328, 2, 100, 3327);
    send(3, 3000, 1000, 0, 671, 2000);
    send(3, 0, 1, 0, 1, 3328);
    send(0, 3328, 3328, 3328, 0, 3327);
    for (int m = 0; m < 4; m++)
      send(m, 0, 0, 0, 0, 0);
    drain();

    rnd_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if ($urandom % 5 == 0)
        idle();
      sendr(int'($urandom % 4));
    end
    drain();
    rnd_en = 1'b0;
    repeat (2) idle();

    for (int i = 0; i < 3; i++)
      sendr(i);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("valid_after_rst", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    send(0, 1, 2, 17, 35, 3296);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
